// File: rtl/control_pipe.sv
// control_pipe: MIPS pipeline control unit. Decodes the ID opcode, carries the
// EX/MEM/WB control bundles through ID/EX, EX/MEM and MEM/WB, detects load-use
// hazards, squashes wrong-path instructions on taken BEQ or J, and keeps
// saturating stall/flush counters.
module control_pipe #(
    parameter int REG_ADDR_W = 5,
    parameter int EN_ADDI    = 1,
    parameter int EN_JUMP    = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [5:0]            id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_branch_taken,
    output logic [3:0]            ex_ctrl,
    output logic                  ex_branch,
    output logic [2:0]            mem_ctrl,
    output logic [1:0]            wb_ctrl,
    output logic [REG_ADDR_W-1:0] wb_reg_addr,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_flush,
    output logic                  id_jump,
    output logic                  illegal_op,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    // Decoded ID-stage control bits
    logic       dec_regdst;
    logic       dec_regwrite;
    logic [1:0] dec_aluop;
    logic       dec_alusrc;
    logic       dec_memtoreg;
    logic       dec_memread;
    logic       dec_memwrite;
    logic       dec_branch;
    logic       dec_jump;
    logic       dec_illegal;
    logic [REG_ADDR_W-1:0] dec_dest;

    // ID/EX register
    logic [3:0]            idex_ex_reg;
    logic [2:0]            idex_m_reg;
    logic [1:0]            idex_wb_reg;
    logic [REG_ADDR_W-1:0] idex_dest_reg;

    // EX/MEM register
    logic [2:0]            exmem_m_reg;
    logic [1:0]            exmem_wb_reg;
    logic [REG_ADDR_W-1:0] exmem_dest_reg;

    // MEM/WB register
    logic [1:0]            memwb_wb_reg;
    logic [REG_ADDR_W-1:0] memwb_dest_reg;

    // Hazard / event terms
    logic stall;
    logic taken;
    logic stall_eff;
    logic flush_event;
    logic bubble;

    // Opcode decode; unknown or disabled opcodes yield all-zero controls
    always_comb begin
        dec_regdst   = 1'b0;
        dec_regwrite = 1'b0;
        dec_aluop    = 2'b00;
        dec_alusrc   = 1'b0;
        dec_memtoreg = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
        dec_branch   = 1'b0;
        dec_jump     = 1'b0;
        dec_illegal  = 1'b0;
        case (id_opcode)
            OP_R: begin
                dec_regdst   = 1'b1;
                dec_regwrite = 1'b1;
                dec_aluop    = 2'b10;
            end
            OP_LW: begin
                dec_alusrc   = 1'b1;
                dec_memtoreg = 1'b1;
                dec_regwrite = 1'b1;
                dec_memread  = 1'b1;
            end
            OP_SW: begin
                dec_alusrc   = 1'b1;
                dec_memwrite = 1'b1;
            end
            OP_BEQ: begin
                dec_branch   = 1'b1;
                dec_aluop    = 2'b01;
            end
            OP_ADDI: begin
                if (EN_ADDI != 0) begin
                    dec_alusrc   = 1'b1;
                    dec_regwrite = 1'b1;
                end else begin
                    dec_illegal  = 1'b1;
                end
            end
            OP_J: begin
                if (EN_JUMP != 0) dec_jump    = 1'b1;
                else              dec_illegal = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Destination register; zero when nothing is written back
    always_comb begin
        dec_dest = '0;
        if (dec_regwrite) dec_dest = dec_regdst ? id_rd : id_rt;
    end

    // Hazard, flush and PC/IF-ID control; everything is quiet during reset
    always_comb begin
        stall = ~reset & idex_m_reg[1] & (idex_dest_reg != '0) &
                ((idex_dest_reg == id_rs) | (idex_dest_reg == id_rt));
        taken       = ~reset & idex_m_reg[2] & ex_branch_taken;
        id_jump     = ~reset & dec_jump;
        // A taken branch squashes the ID instruction, so its stall is moot
        stall_eff   = stall & ~taken;
        flush_event = taken | (id_jump & ~stall);
        bubble      = stall_eff | flush_event;
        pc_write    = ~reset & ~stall_eff;
        if_id_write = ~reset & ~stall_eff;
        if_flush    = flush_event;
        illegal_op  = dec_illegal;
    end

    // Pipeline control registers; ID/EX takes a bubble on stall or flush
    always_ff @(posedge clock) begin
        if (reset) begin
            idex_ex_reg    <= '0;
            idex_m_reg     <= '0;
            idex_wb_reg    <= '0;
            idex_dest_reg  <= '0;
            exmem_m_reg    <= '0;
            exmem_wb_reg   <= '0;
            exmem_dest_reg <= '0;
            memwb_wb_reg   <= '0;
            memwb_dest_reg <= '0;
        end else begin
            if (bubble) begin
                idex_ex_reg   <= '0;
                idex_m_reg    <= '0;
                idex_wb_reg   <= '0;
                idex_dest_reg <= '0;
            end else begin
                idex_ex_reg   <= {dec_regdst, dec_aluop, dec_alusrc};
                idex_m_reg    <= {dec_branch, dec_memread, dec_memwrite};
                idex_wb_reg   <= {dec_regwrite, dec_memtoreg};
                idex_dest_reg <= dec_dest;
            end
            exmem_m_reg    <= idex_m_reg;
            exmem_wb_reg   <= idex_wb_reg;
            exmem_dest_reg <= idex_dest_reg;
            memwb_wb_reg   <= exmem_wb_reg;
            memwb_dest_reg <= exmem_dest_reg;
        end
    end

    // Saturating event counters: index 0 counts stalls, index 1 counts flushes
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_reg [2];

    assign cnt_inc = {flush_event, stall_eff};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            // Count qualifying cycles, holding at all-ones
            always_ff @(posedge clock) begin
                if (reset)
                    cnt_reg[gi] <= '0;
                else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}}))
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
            end
        end
    endgenerate

    assign stall_cnt   = cnt_reg[0];
    assign flush_cnt   = cnt_reg[1];
    assign ex_ctrl     = idex_ex_reg;
    assign ex_branch   = idex_m_reg[2];
    assign mem_ctrl    = exmem_m_reg;
    assign wb_ctrl     = memwb_wb_reg;
    assign wb_reg_addr = memwb_dest_reg;

endmodule
